// File: rtl/event_req_mux_if.sv
// event_req_mux_if: bundles the producer, arbiter and downstream signals of
// event_req_mux.
//   in_vld/in_data/in_rdy : four producer ports, port i at in_data[i*DW +: DW]
//   req                   : request lines to the round-robin arbiter
//   vgnt/egnt/eval        : one-hot grant, encoded grant, grant valid
//   out_vld/out_data/out_port/out_stall : registered, stallable output stage
//   err                   : sticky protocol-error flag
// master = environment side (producers, arbiter, sink); slave = event_req_mux.
interface event_req_mux_if #(
  parameter int DW = 64
);
  logic [3:0]      in_vld;
  logic [4*DW-1:0] in_data;
  logic [3:0]      in_rdy;
  logic [3:0]      req;
  logic [3:0]      vgnt;
  logic [1:0]      egnt;
  logic            eval;
  logic            out_vld;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_port;
  logic            out_stall;
  logic            err;

  modport master (
    output in_vld, in_data, vgnt, egnt, eval, out_stall,
    input  in_rdy, req, out_vld, out_data, out_port, err
  );

  modport slave (
    input  in_vld, in_data, vgnt, egnt, eval, out_stall,
    output in_rdy, req, out_vld, out_data, out_port, err
  );
endinterface

// File: rtl/event_req_mux.sv
// event_req_mux: requester-side front end for a 4-way sticky round-robin
// arbiter. Buffers events from four producer ports in per-port FIFOs, raises
// req[3:0] for non-empty ports, pops the granted FIFO into a registered,
// stallable output stage, and limits consecutive pops from one port so a busy
// port cannot starve the others.
// Ports:
//   clk     : clock, rising-edge
//   reset_n : asynchronous active-low reset
//   bus     : event_req_mux_if.slave (producer, arbiter and output signals)
module event_req_mux #(
  parameter int DW       = 64,
  parameter int DEPTH    = 4,
  parameter int MAXBURST = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  event_req_mux_if.slave       bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAXBURST + 1);

  logic [DW-1:0] mem [4][DEPTH];
  logic [AW-1:0] wr_ptr [4];
  logic [AW-1:0] rd_ptr [4];
  logic [CW-1:0] count  [4];

  logic [3:0]    nonempty;
  logic [3:0]    push;
  logic [3:0]    pop_vec;
  logic [3:0]    mask;
  logic [3:0]    gnt_onehot;
  logic [3:0]    last_onehot;
  logic          bad;
  logic          pop;
  logic [BW-1:0] burst;
  logic [1:0]    last_port;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      nonempty[i]   = (count[i] != '0);
      bus.in_rdy[i] = (count[i] < CW'(DEPTH));
      push[i]       = bus.in_vld[i] && bus.in_rdy[i];
    end
  end

  // A grant is only honoured when it is well-formed; anything else raises err
  // and is otherwise ignored.
  always_comb begin
    gnt_onehot = 4'b0001 << bus.egnt;
    bad        = bus.eval && (bus.out_stall || !nonempty[bus.egnt] ||
                              (bus.vgnt != gnt_onehot));
    pop        = bus.eval && !bad;
    pop_vec    = pop ? gnt_onehot : '0;
  end

  // A saturated port is masked only while someone else is waiting, so a lone
  // requester keeps streaming without a bubble.
  always_comb begin
    last_onehot = 4'b0001 << last_port;
    mask        = '0;
    if ((burst == BW'(MAXBURST)) && ((nonempty & ~last_onehot) != '0))
      mask = last_onehot;
    bus.req = bus.out_stall ? '0 : (nonempty & ~mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (push[i])
          wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop_vec[i])
          rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push[i], pop_vec[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by the counts.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (push[i])
        mem[i][wr_ptr[i]] <= bus.in_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_vld  <= 1'b0;
      bus.out_data <= '0;
      bus.out_port <= '0;
    end else if (!bus.out_stall) begin
      if (pop) begin
        bus.out_vld  <= 1'b1;
        bus.out_data <= mem[bus.egnt][rd_ptr[bus.egnt]];
        bus.out_port <= bus.egnt;
      end else begin
        bus.out_vld  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst     <= '0;
      last_port <= '0;
    end else if (pop) begin
      if (bus.egnt == last_port) begin
        if (burst != BW'(MAXBURST))
          burst <= burst + BW'(1);
      end else begin
        burst     <= BW'(1);
        last_port <= bus.egnt;
      end
    end else if (!bus.out_stall && !bus.eval) begin
      burst <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      bus.err <= 1'b0;
    else if (bad)
      bus.err <= 1'b1;
  end

endmodule
